// File: rtl/instr_decode_rle_if.sv
// Handshake bundle between program fetch, the run-length decoder and the
// execute stage. The decoder uses the slave view. Fetch and execute, or a
// bench standing in for them, use the master view.
interface instr_decode_rle_if #(
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_op;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_last;

  modport slave (
    input  in_valid, in_instr, in_last, out_ready,
    output in_ready, out_valid, out_op, out_cnt, out_last
  );

  modport master (
    output in_valid, in_instr, in_last, out_ready,
    input  in_ready, out_valid, out_op, out_cnt, out_last
  );
endinterface

// File: rtl/instr_decode_rle.sv
// Streaming Brainfuck decoder with run-length merging.
// Program bytes are classified into the eight ops. Anything else is a nop
// and is dropped. Runs of identical > < + - collapse into one {op, count}
// beat, so the execute stage spends one cycle per run. in_last starts a
// flush: the open run is emitted with last=1. A program with no ops at all
// produces the marker {op 0, count 0, last 1}.
module instr_decode_rle #(
  parameter int INSTR_W  = 8,
  parameter int CNT_W    = 8,
  parameter int MERGE_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_decode_rle_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Returns {is_op, op}. Bytes with any bit set above the low eight are nops.
  function automatic logic [3:0] classify(input logic [INSTR_W-1:0] b);
    logic [3:0] r;
    r = 4'b0000;
    if ((b >> 8) == '0) begin
      case (b[7:0])
        8'h3E:   r = 4'b1000; // >
        8'h3C:   r = 4'b1001; // <
        8'h2B:   r = 4'b1010; // +
        8'h2D:   r = 4'b1011; // -
        8'h2E:   r = 4'b1100; // .
        8'h2C:   r = 4'b1101; // ,
        8'h5B:   r = 4'b1110; // [
        8'h5D:   r = 4'b1111; // ]
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  state_e           state_q,     state_d;
  logic             acc_v_q,     acc_v_d;
  logic [2:0]       acc_op_q,    acc_op_d;
  logic [CNT_W-1:0] acc_cnt_q,   acc_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_op_q,    out_op_d;
  logic [CNT_W-1:0] out_cnt_q,   out_cnt_d;
  logic             out_last_q,  out_last_d;

  logic       out_free_s;
  logic       in_ready_s;
  logic       accept_s;
  logic [3:0] cls_s;
  logic       is_op_s;
  logic [2:0] op_s;
  logic       mergeable_s;

  // Classify the incoming byte. Decide whether it extends the open run.
  always_comb begin
    cls_s       = classify(bus.in_instr);
    is_op_s     = cls_s[3];
    op_s        = cls_s[2:0];
    out_free_s  = !out_valid_q || bus.out_ready;
    in_ready_s  = (state_q == ST_RUN) && out_free_s;
    accept_s    = bus.in_valid && in_ready_s;
    // Only > < + - (codes 0..3) merge. A full counter closes the run.
    mergeable_s = (MERGE_EN != 0) && acc_v_q && (op_s == acc_op_q) &&
                  (op_s[2] == 1'b0) && (acc_cnt_q != CNT_MAX);
  end

  // Next state for the FSM, the accumulator and the output register.
  always_comb begin
    state_d     = state_q;
    acc_v_d     = acc_v_q;
    acc_op_d    = acc_op_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;

    // A consumed beat frees the register. A load below overrides this.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          if (is_op_s) begin
            if (mergeable_s) begin
              acc_cnt_d = acc_cnt_q + CNT_ONE;
            end else begin
              // Close the open run, if any, before starting a new one.
              if (acc_v_q) begin
                out_valid_d = 1'b1;
                out_op_d    = acc_op_q;
                out_cnt_d   = acc_cnt_q;
                out_last_d  = 1'b0;
              end else begin
                out_valid_d = out_valid_d;
              end
              acc_v_d   = 1'b1;
              acc_op_d  = op_s;
              acc_cnt_d = CNT_ONE;
            end
          end else begin
            acc_v_d = acc_v_q;
          end
          if (bus.in_last) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (out_free_s) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          if (acc_v_q) begin
            out_op_d  = acc_op_q;
            out_cnt_d = acc_cnt_q;
          end else begin
            // Empty program marker.
            out_op_d  = 3'd0;
            out_cnt_d = '0;
          end
          acc_v_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_RUN;
        acc_v_d = 1'b0;
      end
    endcase
  end

  // State, accumulator and output register. Reset drops any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      acc_v_q     <= 1'b0;
      acc_op_q    <= 3'd0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= 3'd0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_v_q     <= acc_v_d;
      acc_op_q    <= acc_op_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/instr_decode_rle.md
Name: instr_decode_rle

Overview:
- Streaming Brainfuck instruction decoder with run-length merging.
- Accepts raw 8-bit program bytes over a valid/ready handshake and classifies each byte as one of the eight BF ops or a nop; nops are dropped.
- Collapses consecutive identical `+ - > <` into a single op with a repeat count.
- Emits {op, count} beats to the execute stage over a second valid/ready handshake. Sits between program fetch and the datapath, so one `+++++` costs one execute cycle.

Parameters:
- INSTR_W, 8: input byte width; only the low 8 bits are compared, upper bits must be 0 or the byte is a nop.
- CNT_W, 8: repeat-count width; maximum run = 2^CNT_W-1.
- MERGE_EN, 1: 1 = merge runs of + - > <; 0 = every op is emitted with count 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_instr/in_last valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_instr  in  INSTR_W  program byte.
- in_last  in  1  final byte of program; triggers flush.
- out_valid  out  1  out_op/out_cnt/out_last valid.
- out_ready  in  1  consumer accepts the beat.
- out_op  out  3  op code: 0 `>`, 1 `<`, 2 `+`, 3 `-`, 4 `.`, 5 `,`, 6 `[`, 7 `]`.
- out_cnt  out  CNT_W  repeat count (≥1, or 0 for the empty-program marker).
- out_last  out  1  final beat of program.

Behaviour:
- Storage:
  - Accumulator: acc_v, acc_op, acc_cnt.
  - Output register: out_valid, out_op, out_cnt, out_last.
  - Control FSM: RUN, FLUSH.
- Reset (async): state=RUN; acc_v=0, acc_cnt=0; out_valid=0, out_op=0, out_cnt=0, out_last=0. Reset mid-program discards the accumulator and the pending output beat with no partial emission.
- Handshakes:
  - in_ready = (state==RUN) && (!out_valid || out_ready). in_ready is uniform and does not depend on the byte.
  - Input accept = in_valid && in_ready; output transfer = out_valid && out_ready.
  - Output fields must hold stable while out_valid && !out_ready.
- On accept in RUN, with the byte classified combinationally:
  - Nop: no accumulator change.
  - Merge case (MERGE_EN=1, acc_v, byte op == acc_op, op in {`>`,`<`,`+`,`-`}, acc_cnt != max): acc_cnt += 1.
  - Any other op:
    - If acc_v, load the output register with {acc_op, acc_cnt, last=0} and set out_valid=1.
    - Then load the accumulator with {op, 1}, acc_v=1.
  - `.` `,` `[` `]` never merge; `+` followed by `-` never cancels.
  - Saturation: an identical mergeable op arriving with acc_cnt==max closes the run and starts a new one with count 1.
  - If in_last=1 on an accepted beat, process the byte as above, then state → FLUSH.
- FLUSH:
  - in_ready=0.
  - When !out_valid || out_ready, load the output register:
    - acc_v=1: {acc_op, acc_cnt, last=1}.
    - acc_v=0: marker {op 0, cnt 0, last=1}.
  - Then clear acc_v and return to RUN.
- Output register update when no load occurs: an output transfer clears out_valid.
- A load and a transfer in the same cycle leave out_valid=1 with the new data.
- Latency: an op appears on out_valid 1 cycle after the accepted beat that closes its run, or 1 cycle after FLUSH is entered with the output free. Full throughput: 1 byte/cycle with out_ready=1.

Test Plan:
- Bytes `+`,`+`,`+`,`>`(last), out_ready=1 → beats {2,3,0}, {0,1,1}; no other beats.
- Bytes `a`,`+`,`\n`,`+`,` `,`+`(last) → single beat {2,3,1}; nops never cause a beat or break the run.
- CNT_W=2, five `+` then `.`(last) → {2,3,0}, {2,2,0}, {4,1,1}. MERGE_EN=0, `++` (last) → {2,1,0}, {2,1,1}.
- `[`,`[`,`-`,`]`(last) → {6,1},{6,1},{3,1},{7,1,last}; loop/IO ops never merge.
- `+`,`-`,`>` with out_ready held 0 for 5 cycles → in_ready=0 once out_valid is set; out_op/out_cnt stable = {2,1}. Releasing out_ready resumes the sequence with no loss or duplication.
- All-nop program `x`,`y`(last) → one beat {0,0,1}.
- Assert rst mid-run (acc holding `+`×4, out_valid=1) → all outputs 0 in the same cycle; a following `>`(last) yields only {0,1,1}.
